// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings and default frame parameters.
package uart_pkg;

  localparam int unsigned OVERSAMPLING_DEF = 8;
  localparam int unsigned DATA_BITS_DEF    = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_START = 2'b01,
    ST_DATA  = 2'b10,
    ST_STOP  = 2'b11
  } uart_state_e;

endpackage

// File: rtl/uart_rx_if.sv
// Receiver-side bus: baud tick and serial line in, parallel word and status out.
interface uart_rx_if #(
  parameter int unsigned DATA_BITS = uart_pkg::DATA_BITS_DEF
) ();

  logic                 baudpulse_in;
  logic                 rx_serial_in;
  logic [DATA_BITS-1:0] rx_data_out;
  logic                 rx_done_out;
  logic                 rx_busy_out;
  logic                 rx_frame_err_out;

  modport master (
    output baudpulse_in,
    output rx_serial_in,
    input  rx_data_out,
    input  rx_done_out,
    input  rx_busy_out,
    input  rx_frame_err_out
  );

  modport slave (
    input  baudpulse_in,
    input  rx_serial_in,
    output rx_data_out,
    output rx_done_out,
    output rx_busy_out,
    output rx_frame_err_out
  );

endinterface

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for an asynchronous single-bit input.
module uart_sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic sysclk_in,
  input  logic rst_in,
  input  logic async_in,
  output logic sync_out
);

  logic meta;

  // Metastability stage followed by the output stage.
  always_ff @(posedge sysclk_in) begin
    if (rst_in) begin
      meta     <= RESET_VAL;
      sync_out <= RESET_VAL;
    end else begin
      meta     <= async_in;
      sync_out <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: oversampled start-bit qualification, mid-bit sampling, LSB-first.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned OVERSAMPLING = OVERSAMPLING_DEF,
  parameter int unsigned DATA_BITS    = DATA_BITS_DEF
) (
  input  logic     sysclk_in,
  input  logic     rst_in,
  uart_rx_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(OVERSAMPLING);
  localparam int unsigned IDX_W = $clog2(DATA_BITS + 1);

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(OVERSAMPLING / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(OVERSAMPLING - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);

  uart_state_e          state_q;
  uart_state_e          state_d;
  logic                 rx_sync;
  logic                 rx_prev;
  logic [CNT_W-1:0]     tick_q;
  logic [IDX_W-1:0]     idx_q;
  logic [DATA_BITS-1:0] shift_q;
  logic [DATA_BITS-1:0] data_q;
  logic                 done_q;
  logic                 busy_q;
  logic                 err_q;

  logic edge_det;
  logic half_hit;
  logic bit_hit;
  logic tick_clr;
  logic tick_inc;
  logic idx_clr;
  logic idx_inc;
  logic shift_en;
  logic done_d;
  logic err_d;

  uart_sync2 #(
    .RESET_VAL (1'b1)
  ) u_sync (
    .sysclk_in (sysclk_in),
    .rst_in    (rst_in),
    .async_in  (bus.rx_serial_in),
    .sync_out  (rx_sync)
  );

  // Tick-qualified events shared by next-state and control logic.
  assign edge_det = bus.baudpulse_in & rx_prev & ~rx_sync;
  assign half_hit = bus.baudpulse_in & (tick_q == HALF_LAST);
  assign bit_hit  = bus.baudpulse_in & (tick_q == BIT_LAST);

  // State register.
  always_ff @(posedge sysclk_in) begin
    if (rst_in) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (edge_det) state_d = ST_START;
      ST_START: if (half_hit) state_d = rx_sync ? ST_IDLE : ST_DATA;
      ST_DATA:  if (bit_hit && (idx_q == IDX_LAST)) state_d = ST_STOP;
      ST_STOP:  if (bit_hit) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Datapath controls and frame-result strobes per state.
  always_comb begin
    tick_clr = 1'b0;
    tick_inc = 1'b0;
    idx_clr  = 1'b0;
    idx_inc  = 1'b0;
    shift_en = 1'b0;
    done_d   = 1'b0;
    err_d    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (edge_det) tick_clr = 1'b1;
      end
      ST_START: begin
        if (half_hit) begin
          tick_clr = 1'b1;
          idx_clr  = 1'b1;
        end else if (bus.baudpulse_in) begin
          tick_inc = 1'b1;
        end
      end
      ST_DATA: begin
        if (bit_hit) begin
          tick_clr = 1'b1;
          shift_en = 1'b1;
          idx_inc  = 1'b1;
        end else if (bus.baudpulse_in) begin
          tick_inc = 1'b1;
        end
      end
      ST_STOP: begin
        if (bit_hit) begin
          tick_clr = 1'b1;
          done_d   = rx_sync;
          err_d    = ~rx_sync;
        end else if (bus.baudpulse_in) begin
          tick_inc = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Counters, shift register, line history and registered outputs.
  always_ff @(posedge sysclk_in) begin
    if (rst_in) begin
      rx_prev <= 1'b1;
      tick_q  <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      if (bus.baudpulse_in) rx_prev <= rx_sync;

      if (tick_clr)      tick_q <= '0;
      else if (tick_inc) tick_q <= tick_q + CNT_W'(1);

      if (idx_clr)      idx_q <= '0;
      else if (idx_inc) idx_q <= idx_q + IDX_W'(1);

      if (shift_en) shift_q <= {rx_sync, shift_q[DATA_BITS-1:1]};

      if (done_d) data_q <= shift_q;

      done_q <= done_d;
      err_q  <= err_d;
      busy_q <= (state_d == ST_DATA) || (state_d == ST_STOP);
    end
  end

  assign bus.rx_data_out      = data_q;
  assign bus.rx_done_out      = done_q;
  assign bus.rx_busy_out      = busy_q;
  assign bus.rx_frame_err_out = err_q;

endmodule
